// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary-to-BCD converter, one bit per clock (optional BIN2BCD_BLANK_EN)
module bin2bcd_seq #(
    parameter int N = 14,
    parameter int D = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     in,
    output logic             busy,
    output logic             done,
    output logic [4*D-1:0]   bcd,
    output logic             overflow
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [N-1:0]     shreg;
    logic [4*D-1:0]   dig;
    logic [CW-1:0]    cnt;
    logic             ovf_acc;

    logic [4*D-1:0]   dig_adj;
    logic [4*D-1:0]   dig_shift;
    logic [N-1:0]     shreg_shift;
    logic [CW-1:0]    cnt_dec;
    logic             ovf_shift;
    logic [4*D-1:0]   bcd_load;
    logic             accept;
    logic             last;

    // One double-dabble step: add 3 to every digit >= 5 (carry-free), then shift {digits, shreg} left.
    // The bit falling off the top digit means the value does not fit in D digits.
    always_comb begin
        dig_adj = dig;
        for (int i = 0; i < D; i++) begin
            if (dig[4*i +: 4] >= 4'd5) begin
                dig_adj[4*i +: 4] = dig[4*i +: 4] + 4'd3;
            end
        end
        dig_shift   = {dig_adj[4*D-2:0], shreg[N-1]};
        ovf_shift   = ovf_acc | dig_adj[4*D-1];
        shreg_shift = shreg << 1;
        cnt_dec     = cnt - CW'(1);
    end

`ifdef BIN2BCD_BLANK_EN
    logic lead;

    // Leading-zero blanking at result load: zeros above the top nonzero digit become 4'hF.
    // Digit 0 is always shown, and an overflowed result is shown in full.
    always_comb begin
        bcd_load = dig_shift;
        lead     = 1'b1;
        for (int i = D - 1; i >= 1; i--) begin
            if (lead && !ovf_shift && (dig_shift[4*i +: 4] == 4'd0)) begin
                bcd_load[4*i +: 4] = 4'hF;
            end else begin
                lead = 1'b0;
            end
        end
    end
`else
    // Plain digits straight from the shift chain.
    always_comb begin
        bcd_load = dig_shift;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and status outputs; start is only honoured in IDLE and DONE.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt_dec == '0) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Conversion datapath: load on accept, step once per SHIFT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            dig     <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
        end else if (accept) begin
            shreg   <= in;
            dig     <= '0;
            cnt     <= CW'(N);
            ovf_acc <= 1'b0;
        end else if (busy) begin
            shreg   <= shreg_shift;
            dig     <= dig_shift;
            cnt     <= cnt_dec;
            ovf_acc <= ovf_shift;
        end
    end

    // Result registers: updated only with the final step, so intermediate digits never appear.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd      <= '0;
            overflow <= 1'b0;
        end else if (last) begin
            bcd      <= bcd_load;
            overflow <= ovf_shift;
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - scoreboard testbench for bin2bcd_seq
module tb_bin2bcd_seq;

    localparam int N = 14;
    localparam int D = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic [N-1:0]  in;
    logic          busy;
    logic          done;
    logic [4*D-1:0] bcd;
    logic          overflow;

    int tests;
    int fails;

    typedef struct {
        int          val;
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

    exp_t sb[$];

    bin2bcd_seq #(.N(N), .D(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in       (in),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: decimal digits by division, with optional blanking.
    function automatic exp_t model(input int v);
        exp_t e;
        int   r;
        int   p;
        logic seen;
        r = v % 10000;
        e.val = v;
        e.ovf = (v > 9999);
        p = 1;
        for (int i = 0; i < 4; i++) begin
            e.bcd[4*i +: 4] = 4'((r / p) % 10);
            p = p * 10;
        end
`ifdef BIN2BCD_BLANK_EN
        if (!e.ovf) begin
            seen = 1'b0;
            for (int i = 3; i >= 1; i--) begin
                if (!seen && e.bcd[4*i +: 4] == 4'd0) e.bcd[4*i +: 4] = 4'hF;
                else seen = 1'b1;
            end
        end
`else
        seen = 1'b0;
        if (seen) e.bcd = 16'h0;
`endif
        return e;
    endfunction

    // Scoreboard monitor: every done pulse pops one expected result.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done bcd=%h overflow=%b (no result expected)", bcd, overflow);
            end else begin
                e = sb.pop_front();
                tests++;
                if (bcd !== e.bcd) begin
                    fails++;
                    $display("FAIL bcd in=%0d got=%h expected=%h", e.val, bcd, e.bcd);
                end
                tests++;
                if (overflow !== e.ovf) begin
                    fails++;
                    $display("FAIL overflow in=%0d got=%b expected=%b", e.val, overflow, e.ovf);
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input int v, input bit push);
        @(negedge clk);
        start = 1'b1;
        in    = N'(v);
        if (push) sb.push_back(model(v));
        @(posedge clk);
        #1;
        start = 1'b0;
        in    = N'($urandom);
    endtask

    task automatic wait_done(output int c);
        c = 0;
        while (c < 100) begin
            @(posedge clk);
            #1;
            c++;
            if (done) return;
        end
        tests++;
        fails++;
        $display("FAIL done_timeout got=%0d cycles required=done within 100", c);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        in    = '0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL reset_busy got=%b expected=0", busy); end
        tests++; if (done !== 1'b0)     begin fails++; $display("FAIL reset_done got=%b expected=0", done); end
        tests++; if (bcd !== 16'h0)     begin fails++; $display("FAIL reset_bcd got=%h expected=0000", bcd); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got=%b expected=0", overflow); end
        rst = 1'b0;
    endtask

    task automatic test_latency();
        int c;
        do_start(9999, 1'b1);
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL busy_after_accept got=%b expected=1", busy); end
        wait_done(c);
        tests++;
        if (c !== N) begin fails++; $display("FAIL latency got=%0d expected=%0d", c, N); end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL busy_at_done got=%b expected=0", busy); end
    endtask

    task automatic test_patterns();
        int c;
        int vals[4];
        vals[0] = 0; vals[1] = 42; vals[2] = 10000; vals[3] = 16383;
        foreach (vals[i]) begin
            do_start(vals[i], 1'b1);
            wait_done(c);
        end
    endtask

    task automatic test_ignore_busy();
        int c;
        do_start(1234, 1'b1);
        for (int i = 1; i <= 13; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                fails++;
                $display("FAIL busy_hold cycle=%0d got busy=%b done=%b expected busy=1 done=0", i, busy, done);
            end
            if (i == 4) begin start = 1'b1; in = N'(5678); end
            if (i == 5) start = 1'b0;
        end
        wait_done(c);
        tests++;
        if (c !== 1) begin fails++; $display("FAIL ignore_latency got=%0d expected=1", c); end
        repeat (20) @(posedge clk);
    endtask

    task automatic test_back_to_back();
        int t[2];
        int nd;
        nd = 0;
        t[0] = 0; t[1] = 0;
        @(negedge clk);
        start = 1'b1;
        in    = N'(7);
        sb.push_back(model(7));
        @(posedge clk);
        #1;
        in = N'(255);
        sb.push_back(model(255));
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (done && nd < 2) begin t[nd] = c; nd++; end
            if (nd == 1 && !done && start) start = 1'b0;
        end
        start = 1'b0;
        tests++;
        if (nd !== 2) begin fails++; $display("FAIL b2b_count got=%0d expected=2", nd); end
        tests++;
        if (t[1] - t[0] !== N + 1) begin fails++; $display("FAIL b2b_spacing got=%0d expected=%0d", t[1] - t[0], N + 1); end
    endtask

    task automatic test_reset_abort();
        int c;
        do_start(9999, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL abort_busy got=%b expected=0", busy); end
        tests++; if (done !== 1'b0)     begin fails++; $display("FAIL abort_done got=%b expected=0", done); end
        tests++; if (bcd !== 16'h0)     begin fails++; $display("FAIL abort_bcd got=%h expected=0000", bcd); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL abort_overflow got=%b expected=0", overflow); end
        repeat (20) @(posedge clk);
        do_start(321, 1'b1);
        wait_done(c);
    endtask

    task automatic test_sweep();
        int c;
        int extra[10];
        extra[0] = 9998; extra[1] = 9999; extra[2] = 10000; extra[3] = 10001; extra[4] = 16383;
        extra[5] = 9;    extra[6] = 10;   extra[7] = 99;    extra[8] = 100;   extra[9] = 1000;
        for (int v = 0; v < 16384; v += 7) begin
            do_start(v, 1'b1);
            wait_done(c);
        end
        foreach (extra[i]) begin
            do_start(extra[i], 1'b1);
            wait_done(c);
            tests++;
            if (c !== N) begin fails++; $display("FAIL sweep_latency in=%0d got=%0d expected=%0d", extra[i], c, N); end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_latency();
        test_patterns();
        test_ignore_busy();
        test_back_to_back();
        test_reset_abort();
        test_sweep();
        repeat (3) @(posedge clk);
        tests++;
        if (sb.size() !== 0) begin fails++; $display("FAIL scoreboard_drain got=%0d pending expected=0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
